patch_ctrl_seq: RTL and testbench

PATCH_CTRL_SEQ -- requirements
Module: patch_ctrl_seq

---
 rtl/patch_pkg.sv | 55 +++++
 rtl/patch_match.sv | 14 +
 rtl/patch_ctrl_seq.sv | 125 ++++++++++++
 tb/tb_patch_ctrl_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/patch_pkg.sv
// patch_pkg: shared types and cfg_data layout for the patch sequencer.
// Holds the FSM state enum, field offsets/widths and the hit ceiling.
package patch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    ARMED  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam int HIT_MAX = 255;

  localparam int DEF_OBS_W = 8;
  localparam int DEF_CTL_W = 4;
  localparam int DEF_DUR_W = 8;

  // cfg_data, LSB first:
  // obs_value, obs_mask, ctl_value, ctl_mask, duration, rearm
  function automatic int ofs_obs_mask(int ow);
    return ow;
  endfunction

  function automatic int ofs_ctl_value(int ow);
    return 2 * ow;
  endfunction

  function automatic int ofs_ctl_mask(int ow, int cw);
    return 2 * ow + cw;
  endfunction

  function automatic int ofs_dur(int ow, int cw);
    return 2 * ow + 2 * cw;
  endfunction

  function automatic int ofs_rearm(int ow, int cw, int dw);
    return 2 * ow + 2 * cw + dw;
  endfunction

  function automatic int cfg_w(int ow, int cw, int dw);
    return 2 * ow + 2 * cw + dw + 1;
  endfunction

  localparam int DEF_CFG_W =
    cfg_w(DEF_OBS_W, DEF_CTL_W, DEF_DUR_W);
  localparam int DEF_OFS_OBS_MASK = DEF_OBS_W;
  localparam int DEF_OFS_CTL_VALUE = 2 * DEF_OBS_W;
  localparam int DEF_OFS_CTL_MASK =
    2 * DEF_OBS_W + DEF_CTL_W;
  localparam int DEF_OFS_DUR =
    2 * DEF_OBS_W + 2 * DEF_CTL_W;
  localparam int DEF_OFS_REARM =
    2 * DEF_OBS_W + 2 * DEF_CTL_W + DEF_DUR_W;

endpackage

// File: rtl/patch_match.sv
// patch_match: masked equality comparator, purely combinational.
// Ports: obs, value, mask in; match out.
module patch_match #(
  parameter int OBS_W = 8
) (
  input  logic [OBS_W-1:0] obs,
  input  logic [OBS_W-1:0] value,
  input  logic [OBS_W-1:0] mask,
  output logic             match
);

  assign match = (obs & mask) == (value & mask);

endmodule

// File: rtl/patch_ctrl_seq.sv
// patch_ctrl_seq: match-triggered override of controlled signals.
// Ports: cfg handshake, arm/disarm, obs_in, ctl_in/out, status.
module patch_ctrl_seq #(
  parameter int OBS_W = 8,
  parameter int CTL_W = 4,
  parameter int DUR_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [2*OBS_W+2*CTL_W+DUR_W:0]   cfg_data,
  input  logic                             arm,
  input  logic                             disarm,
  input  logic [OBS_W-1:0]                 obs_in,
  input  logic [CTL_W-1:0]                 ctl_in,
  output logic [CTL_W-1:0]                 ctl_out,
  output logic                             trig,
  output logic                             active,
  output logic [1:0]                       state,
  output logic [7:0]                       hit_cnt
);

  import patch_pkg::*;

  localparam int CW = cfg_w(OBS_W, CTL_W, DUR_W);
  localparam int OM = ofs_obs_mask(OBS_W);
  localparam int CV = ofs_ctl_value(OBS_W);
  localparam int CM = ofs_ctl_mask(OBS_W, CTL_W);
  localparam int DU = ofs_dur(OBS_W, CTL_W);
  localparam int RA = ofs_rearm(OBS_W, CTL_W, DUR_W);

  state_t           st, st_nxt;
  logic [CW-1:0]    cfg_q;
  logic [DUR_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             match;

  logic [OBS_W-1:0] obs_value;
  logic [OBS_W-1:0] obs_mask;
  logic [CTL_W-1:0] ctl_value;
  logic [CTL_W-1:0] ctl_mask;
  logic [DUR_W-1:0] duration;
  logic             rearm;

  assign obs_value = cfg_q[0 +: OBS_W];
  assign obs_mask  = cfg_q[OM +: OBS_W];
  assign ctl_value = cfg_q[CV +: CTL_W];
  assign ctl_mask  = cfg_q[CM +: CTL_W];
  assign duration  = cfg_q[DU +: DUR_W];
  assign rearm     = cfg_q[RA];

  patch_match #(
    .OBS_W (OBS_W)
  ) u_match (
    .obs   (obs_in),
    .value (obs_value),
    .mask  (obs_mask),
    .match (match)
  );

  assign cfg_ready = (st == IDLE) || (st == CFG);
  assign accept    = cfg_valid && cfg_ready;
  assign active    = (st == ACTIVE);
  assign state     = st;
  assign ctl_out   = active
    ? ((ctl_in & ~ctl_mask) | (ctl_value & ctl_mask))
    : ctl_in;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    trig    = 1'b0;
    unique case (st)
      IDLE: begin
        if (accept) st_nxt = CFG;
      end
      CFG: begin
        // a fresh config wins over arm in the same cycle
        if (accept)   st_nxt = CFG;
        else if (arm) st_nxt = ARMED;
      end
      ARMED: begin
        if (disarm) begin
          st_nxt = CFG;
        end else if (match) begin
          trig    = 1'b1;
          st_nxt  = ACTIVE;
          cnt_nxt = duration;
        end
      end
      ACTIVE: begin
        // duration 0 loads cnt=0, which never reaches 1: hold
        if (disarm) begin
          st_nxt  = CFG;
          cnt_nxt = '0;
        end else if (cnt == DUR_W'(1)) begin
          st_nxt  = rearm ? ARMED : CFG;
          cnt_nxt = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - DUR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      cfg_q   <= '0;
      hit_cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (accept) begin
        cfg_q   <= cfg_data;
        hit_cnt <= '0;
      end else if (trig && hit_cnt != 8'(HIT_MAX)) begin
        hit_cnt <= hit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_patch_ctrl_seq.sv
// tb_patch_ctrl_seq: directed bench for patch_ctrl_seq.
// Drives inputs #1 after posedge; checks before the next edge.
module tb_patch_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [32:0] cfg_data;
  logic        arm;
  logic        disarm;
  logic [7:0]  obs_in;
  logic [3:0]  ctl_in;
  logic [3:0]  ctl_out;
  logic        trig;
  logic        active;
  logic [1:0]  state;
  logic [7:0]  hit_cnt;

  int checks;
  int errors;

  patch_ctrl_seq #(
    .OBS_W (8),
    .CTL_W (4),
    .DUR_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .arm       (arm),
    .disarm    (disarm),
    .obs_in    (obs_in),
    .ctl_in    (ctl_in),
    .ctl_out   (ctl_out),
    .trig      (trig),
    .active    (active),
    .state     (state),
    .hit_cnt   (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] pack(
    input logic       r,
    input logic [7:0] d,
    input logic [3:0] cm,
    input logic [3:0] cv,
    input logic [7:0] om,
    input logic [7:0] ov);
    return {r, d, cm, cv, om, ov};
  endfunction

  task automatic load_cfg(input logic [32:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    arm       = 1'b0;
    disarm    = 1'b0;
    obs_in    = 8'h00;
    ctl_in    = 4'h9;
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_hit", 32'(hit_cnt), 32'd0);
    check("rst_ctl", 32'(ctl_out), 32'h9);
    tick();
    rst_n = 1'b1;
    tick();

    // arm ignored in IDLE
    do_arm();
    check("idle_arm", 32'(state), 32'd0);

    // one-shot override, duration 3
    load_cfg(pack(1'b0, 8'd3, 4'h3, 4'hF, 8'hFF, 8'hA5));
    check("cfg_state", 32'(state), 32'd1);
    do_arm();
    check("armed", 32'(state), 32'd2);
    check("armed_ready", 32'(cfg_ready), 32'd0);
    obs_in = 8'h00;
    #1;
    check("nomatch_trig", 32'(trig), 32'd0);
    obs_in = 8'hA5;
    #1;
    check("n_trig", 32'(trig), 32'd1);
    check("n_ctl", 32'(ctl_out), 32'h9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovr_state", 32'(state), 32'd3);
      check("ovr_ctl", 32'(ctl_out), 32'hB);
      check("ovr_notrig", 32'(trig), 32'd0);
    end
    tick();
    check("n4_state", 32'(state), 32'd1);
    check("n4_ctl", 32'(ctl_out), 32'h9);
    check("n4_hit", 32'(hit_cnt), 32'd1);

    // rearm: pulses every 4 cycles, then saturation
    load_cfg(pack(1'b1, 8'd3, 4'h3, 4'hF, 8'hFF, 8'hA5));
    check("accept_clr", 32'(hit_cnt), 32'd0);
    do_arm();
    for (int c = 0; c <= 8; c++) begin
      check("rearm_trig", 32'(trig), 32'((c % 4) == 0));
      tick();
    end
    check("hit3", 32'(hit_cnt), 32'd3);
    for (int c = 0; c < 1200; c++) tick();
    check("hit_sat", 32'(hit_cnt), 32'd255);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("disarm_cfg", 32'(state), 32'd1);

    // duration 0 holds until disarm
    ctl_in = 4'h4;
    load_cfg(pack(1'b0, 8'd0, 4'h3, 4'hF, 8'hFF, 8'hA5));
    do_arm();
    #1;
    check("d0_trig", 32'(trig), 32'd1);
    tick();
    obs_in = 8'h00;
    for (int i = 0; i < 20; i++) begin
      check("d0_active", 32'(active), 32'd1);
      check("d0_ctl", 32'(ctl_out), 32'h7);
      tick();
    end
    disarm = 1'b1;
    #1;
    check("d0_dis_hold", 32'(ctl_out), 32'h7);
    tick();
    disarm = 1'b0;
    check("d0_dis_state", 32'(state), 32'd1);
    check("d0_dis_ctl", 32'(ctl_out), 32'h4);

    // disarm beats a match in ARMED
    load_cfg(pack(1'b0, 8'd3, 4'h3, 4'hF, 8'hFF, 8'hA5));
    do_arm();
    obs_in = 8'hA5;
    disarm = 1'b1;
    #1;
    check("dm_trig", 32'(trig), 32'd0);
    tick();
    disarm = 1'b0;
    obs_in = 8'h00;
    check("dm_state", 32'(state), 32'd1);
    check("dm_hit", 32'(hit_cnt), 32'd0);

    // config offered while ARMED is not taken
    do_arm();
    cfg_valid = 1'b1;
    cfg_data  = pack(1'b0, 8'd5, 4'h3, 4'hF, 8'h00, 8'h00);
    #1;
    check("armed_noready", 32'(cfg_ready), 32'd0);
    tick();
    cfg_valid = 1'b0;
    check("armed_noacc", 32'(state), 32'd2);
    check("armed_notrig", 32'(trig), 32'd0);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;

    // mask 0 matches anything
    load_cfg(pack(1'b0, 8'd5, 4'h3, 4'hF, 8'h00, 8'h00));
    do_arm();
    obs_in = 8'h3C;
    #1;
    check("mask0_trig", 32'(trig), 32'd1);
    tick();
    ctl_in = 4'h0;
    #1;
    check("pre_rst_act", 32'(active), 32'd1);
    check("pre_rst_ctl", 32'(ctl_out), 32'h3);

    // async reset in ACTIVE releases at once
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ctl", 32'(ctl_out), 32'h0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    check("arst_hit", 32'(hit_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst", 32'(state), 32'd0);
    do_arm();
    check("post_rst_arm", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
